// File: rtl/fb_read_arbiter.sv
// -----------------------------------------------------------------------------
// fb_read_arbiter
//
// Read-side SDRAM scheduler. Shares the single SDRAM read port between the VGA
// display refill path (fifo_big) and the MobileNet input reader. Every grant is
// one fixed-length burst of BURST words. Display refill is urgent below LOW_WM
// and otherwise only takes bandwidth the CNN leaves unused. A frame_start pulse
// is remembered and serviced at the next idle point by clearing the display
// FIFO and rewinding the display address to FB_BASE.
//
// Ports:
//   clk_sdram, rst         sole clock, synchronous active-high reset
//   frame_start            one-cycle frame restart request
//   fifo_wrusedw           display FIFO fill level (write side)
//   wr_fifo                display FIFO write strobe, qualifies rd_data
//   fifo_clr               one-cycle display FIFO clear pulse
//   frame_wrap             one-cycle pulse when the display address wraps
//   cnn_req/cnn_addr       CNN burst request and start address
//   cnn_ack                CNN command accepted by the SDRAM controller
//   cnn_rvalid             CNN data beat valid, qualifies rd_data
//   rd_req/rd_addr         burst read command to the SDRAM controller
//   rd_ack                 command accepted (one-cycle pulse)
//   rd_valid/rd_data       read data beats (data routed externally)
//
// Optional feature (define FB_READ_ARB_STATS_EN):
//   stat_urgent            saturating count of urgent display grants
//   stat_cnn               saturating count of CNN grants
// -----------------------------------------------------------------------------
module fb_read_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int FB_BASE    = 0,
  parameter int FB_WORDS   = 76800,
  parameter int BURST      = 8,
  parameter int FIFO_DEPTH = 4096,
  parameter int LOW_WM     = 1024
) (
  input  logic              clk_sdram,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [11:0]       fifo_wrusedw,
  output logic              wr_fifo,
  output logic              fifo_clr,
  output logic              frame_wrap,
  input  logic              cnn_req,
  input  logic [ADDR_W-1:0] cnn_addr,
  output logic              cnn_ack,
  output logic              cnn_rvalid,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data
`ifdef FB_READ_ARB_STATS_EN
  ,
  output logic [15:0]       stat_urgent,
  output logic [15:0]       stat_cnn
`endif
);

  localparam int BEAT_W = $clog2(BURST);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] END_A     = ADDR_W'(FB_BASE + FB_WORDS);
  localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
  localparam int unsigned LOW_LVL    = 32'(LOW_WM);
  // Leave room for the burst in flight plus the one being requested.
  localparam int unsigned REFILL_LVL = 32'(FIFO_DEPTH - 2 * BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISP_CMD,
    S_DISP_DATA,
    S_CNN_CMD,
    S_CNN_DATA,
    S_FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              flush_pend_q, flush_pend_d;
  logic              rd_req_q, rd_req_d;
  logic              fifo_clr_q, fifo_clr_d;
  logic              frame_wrap_q, frame_wrap_d;
  logic [ADDR_W-1:0] disp_next;
  logic [31:0]       lvl;
  logic              urgent_lvl;

  // rd_data goes straight from the controller to fifo_big and the CNN; the
  // arbiter only qualifies it, so the port is deliberately left unread.
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;

  assign lvl        = 32'(fifo_wrusedw);
  assign urgent_lvl = (lvl < LOW_LVL);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    disp_addr_d  = disp_addr_q;
    rd_addr_d    = rd_addr_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q | frame_start;
    rd_req_d     = rd_req_q;
    fifo_clr_d   = 1'b0;
    frame_wrap_d = 1'b0;
    disp_next    = disp_addr_q + BURST_A;

    unique case (state_q)
      S_IDLE: begin
        if (flush_pend_q) begin
          state_d    = S_FLUSH;
          fifo_clr_d = 1'b1;
        end else if (urgent_lvl) begin
          state_d   = S_DISP_CMD;
          rd_req_d  = 1'b1;
          rd_addr_d = disp_addr_q;
        end else if (cnn_req) begin
          state_d   = S_CNN_CMD;
          rd_req_d  = 1'b1;
          rd_addr_d = cnn_addr;
        end else if (lvl <= REFILL_LVL) begin
          state_d   = S_DISP_CMD;
          rd_req_d  = 1'b1;
          rd_addr_d = disp_addr_q;
        end
      end

      S_DISP_CMD, S_CNN_CMD: begin
        if (rd_ack) begin
          rd_req_d = 1'b0;
          beat_d   = '0;
          state_d  = (state_q == S_DISP_CMD) ? S_DISP_DATA : S_CNN_DATA;
        end
      end

      S_DISP_DATA, S_CNN_DATA: begin
        if (rd_valid) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
            if (state_q == S_DISP_DATA) begin
              if (disp_next == END_A) begin
                disp_addr_d  = BASE_A;
                frame_wrap_d = 1'b1;
              end else begin
                disp_addr_d = disp_next;
              end
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      S_FLUSH: begin
        // A frame_start landing here is absorbed by this flush.
        disp_addr_d  = BASE_A;
        flush_pend_d = 1'b0;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sdram) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      disp_addr_q  <= BASE_A;
      rd_addr_q    <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      rd_req_q     <= 1'b0;
      fifo_clr_q   <= 1'b0;
      frame_wrap_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_addr_q  <= disp_addr_d;
      rd_addr_q    <= rd_addr_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      rd_req_q     <= rd_req_d;
      fifo_clr_q   <= fifo_clr_d;
      frame_wrap_q <= frame_wrap_d;
    end
  end

  // Beat strobes and the CNN ack follow the controller combinationally so
  // every beat is qualified in the same cycle it arrives.
  assign wr_fifo    = (state_q == S_DISP_DATA) && rd_valid;
  assign cnn_rvalid = (state_q == S_CNN_DATA) && rd_valid;
  assign cnn_ack    = (state_q == S_CNN_CMD) && rd_ack;
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign fifo_clr   = fifo_clr_q;
  assign frame_wrap = frame_wrap_q;

`ifdef FB_READ_ARB_STATS_EN
  logic [15:0] stat_urgent_q, stat_urgent_d;
  logic [15:0] stat_cnn_q, stat_cnn_d;
  logic        urgent_grant, cnn_grant;

  // Grants are counted at the IDLE decision, mirroring the priority order.
  assign urgent_grant = (state_q == S_IDLE) && !flush_pend_q && urgent_lvl;
  assign cnn_grant    = (state_q == S_IDLE) && !flush_pend_q && !urgent_lvl && cnn_req;

  always_comb begin
    stat_urgent_d = stat_urgent_q;
    stat_cnn_d    = stat_cnn_q;
    if (urgent_grant && (stat_urgent_q != 16'hFFFF)) stat_urgent_d = stat_urgent_q + 16'd1;
    if (cnn_grant && (stat_cnn_q != 16'hFFFF))       stat_cnn_d    = stat_cnn_q + 16'd1;
  end

  always_ff @(posedge clk_sdram) begin
    if (rst) begin
      stat_urgent_q <= '0;
      stat_cnn_q    <= '0;
    end else begin
      stat_urgent_q <= stat_urgent_d;
      stat_cnn_q    <= stat_cnn_d;
    end
  end

  assign stat_urgent = stat_urgent_q;
  assign stat_cnn    = stat_cnn_q;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_read_arbiter
//
// Self-checking bench for fb_read_arbiter. An SDRAM controller stand-in answers
// read commands with a configurable ack delay and random beat gaps. A
// burst-level reference model predicts every output each cycle; directed
// sections pin the model with hand-computed addresses and pulse counts, and a
// randomized section mixes FIFO levels, CNN requests, frame starts and a reset.
// A small frame (40 bursts) keeps the wrap test short.
// -----------------------------------------------------------------------------
module tb_fb_read_arbiter;

  localparam int ADDR_W     = 24;
  localparam int TB_BASE    = 'h100;
  localparam int TB_WORDS   = 320;
  localparam int BURST      = 8;
  localparam int FIFO_DEPTH = 4096;
  localparam int LOW_WM     = 1024;
  localparam int BURSTS_PER_FRAME = TB_WORDS / BURST;

  logic              clk_sdram = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic [11:0]       fifo_wrusedw = 12'd0;
  logic              wr_fifo, fifo_clr, frame_wrap;
  logic              cnn_req = 1'b0;
  logic [ADDR_W-1:0] cnn_addr = '0;
  logic              cnn_ack, cnn_rvalid;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack, rd_valid;
  logic [15:0]       rd_data;
`ifdef FB_READ_ARB_STATS_EN
  logic [15:0]       stat_urgent, stat_cnn;
`endif

  always #5 clk_sdram = ~clk_sdram;

  fb_read_arbiter #(
    .ADDR_W    (ADDR_W),
    .FB_BASE   (TB_BASE),
    .FB_WORDS  (TB_WORDS),
    .BURST     (BURST),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LOW_WM    (LOW_WM)
  ) dut (
    .clk_sdram   (clk_sdram),
    .rst         (rst),
    .frame_start (frame_start),
    .fifo_wrusedw(fifo_wrusedw),
    .wr_fifo     (wr_fifo),
    .fifo_clr    (fifo_clr),
    .frame_wrap  (frame_wrap),
    .cnn_req     (cnn_req),
    .cnn_addr    (cnn_addr),
    .cnn_ack     (cnn_ack),
    .cnn_rvalid  (cnn_rvalid),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
`ifdef FB_READ_ARB_STATS_EN
    ,
    .stat_urgent (stat_urgent),
    .stat_cnn    (stat_cnn)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // SDRAM controller stand-in
  // ---------------------------------------------------------------------------
  int ack_lo = 2;
  int ack_hi = 2;
  int gap_pct = 0;

  initial begin : sdram_ctrl
    int c_st;
    int dly;
    int left;
    c_st = 0; dly = 0; left = 0;
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = 16'h0;
    forever begin
      @(posedge clk_sdram); #2;
      rd_ack = 1'b0;
      rd_valid = 1'b0;
      if (rst) begin
        c_st = 0;
      end else begin
        case (c_st)
          0: if (rd_req) begin
            dly = $urandom_range(ack_hi, ack_lo);
            if (dly == 0) begin rd_ack = 1'b1; left = BURST; c_st = 2; end
            else c_st = 1;
          end
          1: begin
            dly--;
            if (dly == 0) begin rd_ack = 1'b1; left = BURST; c_st = 2; end
          end
          2: if ($urandom_range(99, 0) >= gap_pct) begin
            rd_valid = 1'b1;
            rd_data = 16'($urandom);
            left--;
            if (left == 0) c_st = 0;
          end
          default: c_st = 0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Burst-level reference model and per-cycle compare
  // ---------------------------------------------------------------------------
  typedef enum {P_IDLE, P_CMD, P_DATA, P_FLUSH} phase_e;
  phase_e            ph = P_IDLE;
  bit                m_valid = 1'b0;
  bit                m_cnn, m_pend, m_wrap;
  int                m_beats;
  int unsigned       m_disp;
  logic [ADDR_W-1:0] m_addr;
  int                m_urg, m_ncnn;

  // Observation counters for directed checks
  int                n_wr, n_cv, n_ack, n_wrap, n_clr;
  logic [ADDR_W-1:0] cmd_addr[$];
  bit                req_prev = 1'b0;

  task automatic model_reset();
    ph = P_IDLE; m_cnn = 0; m_pend = 0; m_wrap = 0; m_beats = 0;
    m_disp = TB_BASE; m_addr = '0; m_urg = 0; m_ncnn = 0;
  endtask

  task automatic grant_display(input bit urgent);
    ph = P_CMD; m_cnn = 0; m_addr = ADDR_W'(m_disp);
    if (urgent && m_urg < 65535) m_urg++;
  endtask

  // Advance the model across one rising edge using the inputs now present.
  task automatic model_step();
    int unsigned lvl;
    bit pend_seen;
    lvl = fifo_wrusedw;
    pend_seen = m_pend;
    m_wrap = 0;
    if (frame_start) m_pend = 1;
    case (ph)
      P_IDLE: begin
        if (pend_seen) ph = P_FLUSH;
        else if (lvl < LOW_WM) grant_display(1);
        else if (cnn_req) begin
          ph = P_CMD; m_cnn = 1; m_addr = cnn_addr;
          if (m_ncnn < 65535) m_ncnn++;
        end
        else if (lvl + 2 * BURST <= FIFO_DEPTH) grant_display(0);
      end
      P_CMD: if (rd_ack) begin ph = P_DATA; m_beats = 0; end
      P_DATA: if (rd_valid) begin
        m_beats++;
        if (m_beats == BURST) begin
          ph = P_IDLE;
          if (!m_cnn) begin
            m_disp += BURST;
            if (m_disp == TB_BASE + TB_WORDS) begin m_disp = TB_BASE; m_wrap = 1; end
          end
        end
      end
      P_FLUSH: begin m_disp = TB_BASE; m_pend = 0; ph = P_IDLE; end
      default: ph = P_IDLE;
    endcase
  endtask

  always @(negedge clk_sdram) begin
    if (m_valid) begin
      check("rd_req",     32'(rd_req),     32'(ph == P_CMD));
      check("rd_addr",    32'(rd_addr),    32'(m_addr));
      check("wr_fifo",    32'(wr_fifo),    32'(ph == P_DATA && !m_cnn && rd_valid));
      check("cnn_rvalid", 32'(cnn_rvalid), 32'(ph == P_DATA && m_cnn && rd_valid));
      check("cnn_ack",    32'(cnn_ack),    32'(ph == P_CMD && m_cnn && rd_ack));
      check("fifo_clr",   32'(fifo_clr),   32'(ph == P_FLUSH));
      check("frame_wrap", 32'(frame_wrap), 32'(m_wrap));
`ifdef FB_READ_ARB_STATS_EN
      check("stat_urgent", 32'(stat_urgent), 32'(m_urg));
      check("stat_cnn",    32'(stat_cnn),    32'(m_ncnn));
`endif
    end
    if (rd_req && !req_prev) cmd_addr.push_back(rd_addr);
    req_prev = rd_req;
    if (wr_fifo)    n_wr++;
    if (cnn_rvalid) n_cv++;
    if (cnn_ack)    n_ack++;
    if (frame_wrap) n_wrap++;
    if (fifo_clr)   n_clr++;
    if (rst) begin
      model_reset();
      m_valid = 1'b1;
    end else if (m_valid) begin
      model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // One clock: frame_start is a single-cycle pulse and a CNN request is
  // withdrawn once it has been acknowledged.
  task automatic tick();
    bit ack_now;
    @(negedge clk_sdram);
    ack_now = cnn_ack;
    @(posedge clk_sdram); #1;
    frame_start = 1'b0;
    if (ack_now) cnn_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_wr = 0; n_cv = 0; n_ack = 0; n_wrap = 0; n_clr = 0;
    cmd_addr.delete();
  endtask

  task automatic wait_cmds(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (cmd_addr.size() < n && k < budget) begin tick(); k++; end
    check(name, 32'(cmd_addr.size() >= n), 32'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int k;
    int snap;

    // Reset state
    do_reset();
    check("reset_rd_req",     32'(rd_req),     32'd0);
    check("reset_rd_addr",    32'(rd_addr),    32'd0);
    check("reset_wr_fifo",    32'(wr_fifo),    32'd0);
    check("reset_fifo_clr",   32'(fifo_clr),   32'd0);
    check("reset_frame_wrap", 32'(frame_wrap), 32'd0);
    check("reset_cnn_ack",    32'(cnn_ack),    32'd0);

    // Empty FIFO: first burst at the frame base, 8 beats, next one 8 words on
    wait_cmds("t1_two_cmds", 2, 100);
    check("t1_first_addr", 32'(cmd_addr[0]), 32'h100);
    check("t1_next_addr",  32'(cmd_addr[1]), 32'h108);
    check("t1_beats",      32'(n_wr),        32'd8);

    // Nearly full FIFO and no CNN traffic: the port stays quiet
    fifo_wrusedw = 12'd4090;
    repeat (30) tick();
    snap = cmd_addr.size();
    repeat (50) tick();
    check("t3_no_new_cmd", 32'(cmd_addr.size()), 32'(snap));
    check("t3_rd_req_low", 32'(rd_req), 32'd0);

    // Urgent display beats a pending CNN request; at 2000 the CNN wins
    rst = 1'b1;
    fifo_wrusedw = 12'd500;
    cnn_req = 1'b1;
    cnn_addr = 24'h100000;
    do_reset();
    wait_cmds("t2_disp_cmd", 1, 50);
    fifo_wrusedw = 12'd2000;
    wait_cmds("t2_cnn_cmd", 2, 100);
    check("t2_disp_first", 32'(cmd_addr[0]), 32'h100);
    check("t2_cnn_addr",   32'(cmd_addr[1]), 32'h100000);
    repeat (20) tick();
    check("t2_cnn_ack_once", 32'(n_ack), 32'd1);
    check("t2_cnn_beats",    32'(n_cv),  32'd8);
    fifo_wrusedw = 12'd4090;
    repeat (20) tick();

    // Whole frame of display bursts: one wrap, then back to the base
    rst = 1'b1;
    fifo_wrusedw = 12'd0;
    ack_lo = 0; ack_hi = 0; gap_pct = 0;
    do_reset();
    wait_cmds("t4_frame_cmds", BURSTS_PER_FRAME + 1, 700);
    check("t4_last_addr",  32'(cmd_addr[BURSTS_PER_FRAME - 1]), 32'(TB_BASE + TB_WORDS - BURST));
    check("t4_wrap_addr",  32'(cmd_addr[BURSTS_PER_FRAME]),     32'(TB_BASE));
    check("t4_wrap_count", 32'(n_wrap), 32'd1);

    // frame_start during beat 3: burst completes, one clear, restart at base
    do_reset();
    wait_cmds("t5_first_cmd", 1, 50);
    k = 0;
    while (n_wr < 2 && k < 50) begin tick(); k++; end
    check("t5_beat2_seen", 32'(n_wr), 32'd2);
    frame_start = 1'b1;
    wait_cmds("t5_after_flush", 2, 60);
    check("t5_burst_done", 32'(n_wr),        32'd8);
    check("t5_one_clear",  32'(n_clr),       32'd1);
    check("t5_base_addr",  32'(cmd_addr[1]), 32'(TB_BASE));

`ifdef FB_READ_ARB_STATS_EN
    // Three CNN grants are counted; reset clears the counters
    rst = 1'b1;
    fifo_wrusedw = 12'd4090;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cnn_req = 1'b1;
      cnn_addr = ADDR_W'(24'h200000 + i * BURST);
      k = 0;
      while (cnn_req && k < 50) begin tick(); k++; end
      check("t6_cnn_acked", 32'(cnn_req), 32'd0);
      repeat (12) tick();
    end
    check("t6_stat_cnn",    32'(stat_cnn),    32'd3);
    check("t6_stat_urgent", 32'(stat_urgent), 32'd0);
    do_reset();
    check("t6_stat_cnn_rst", 32'(stat_cnn), 32'd0);
`endif

    // Randomized traffic with a reset in the middle
    ack_lo = 0; ack_hi = 3; gap_pct = 30;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99, 0) < 5) begin
        case ($urandom_range(4, 0))
          0: fifo_wrusedw = 12'($urandom_range(4095, 0));
          1: fifo_wrusedw = 12'(LOW_WM - 1);
          2: fifo_wrusedw = 12'(LOW_WM);
          3: fifo_wrusedw = 12'(FIFO_DEPTH - 2 * BURST);
          default: fifo_wrusedw = 12'(FIFO_DEPTH - 2 * BURST + 1);
        endcase
      end
      if (!cnn_req && $urandom_range(99, 0) < 10) begin
        cnn_req = 1'b1;
        cnn_addr = ADDR_W'($urandom) & 24'hFFFFF8;
      end
      if ($urandom_range(99, 0) < 1) frame_start = 1'b1;
      if (i == 2000) do_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_read_arbiter.md
# fb_read_arbiter

Read-side SDRAM scheduler that shares the single SDRAM read port between VGA display refill and the MobileNet input reader. It issues fixed-length bursts, keeps the display FIFO (`fifo_big`) topped up by driving its write strobe, restarts the frame address on every frame start, and grants the remaining bandwidth to the CNN. It sits in the `clk_sdram` domain between the SDRAM controller and `fifo_big`/CNN datapath.

## Interface
Parameters:
- `ADDR_W`, 24: SDRAM word-address width.
- `FB_BASE`, 0: first word of the 320x240 RGB565 frame buffer.
- `FB_WORDS`, 76800: frame size in words; must be a multiple of `BURST`.
- `BURST`, 8: words per read burst (power of two, 2..64).
- `FIFO_DEPTH`, 4096: display FIFO depth in words.
- `LOW_WM`, 1024: below this level, display refill is urgent.

Ports:
- `clk_sdram` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse, already synchronous to `clk_sdram`; requests frame restart.
- `fifo_wrusedw` in 12: display FIFO write-side fill level.
- `wr_fifo` out 1: display FIFO write strobe (qualifies `rd_data`).
- `fifo_clr` out 1: one-cycle clear pulse to display FIFO.
- `frame_wrap` out 1: one-cycle pulse when the display address wraps.
- `cnn_req` in 1: CNN read request; held until `cnn_ack`.
- `cnn_addr` in ADDR_W: CNN burst start address; stable while `cnn_req`.
- `cnn_ack` out 1: CNN command accepted.
- `cnn_rvalid` out 1: CNN data beat valid (qualifies `rd_data`).
- `rd_req` out 1: burst read command to SDRAM controller.
- `rd_addr` out ADDR_W: burst start address.
- `rd_ack` in 1: command accepted (one-cycle pulse).
- `rd_valid` in 1: read data beat valid.
- `rd_data` in 16: read data, passed through externally to FIFO and CNN.

## Operation
- States: IDLE, DISP_CMD, DISP_DATA, CNN_CMD, CNN_DATA, FLUSH.
- `flush_pend` latches on `frame_start` in any state; cleared only in FLUSH. A second `frame_start` while pending has no effect.
- IDLE priority (first true wins): `flush_pend` -> FLUSH; `fifo_wrusedw < LOW_WM` -> DISP_CMD; `cnn_req` -> CNN_CMD (captures `cnn_addr` into `rd_addr`); `fifo_wrusedw <= FIFO_DEPTH - 2*BURST` -> DISP_CMD (loads `disp_addr`); else stay.
- DISP_CMD/CNN_CMD: `rd_req`=1, `rd_addr` stable until `rd_ack`; on `rd_ack` -> matching DATA state, beat counter=0. `cnn_ack`=1 in the `rd_ack` cycle of CNN_CMD.
- DATA states: `wr_fifo` (DISP) or `cnn_rvalid` (CNN) = `rd_valid` combinationally; count beats; after beat `BURST` -> IDLE. Gaps between beats are allowed.
- Display address: on leaving DISP_DATA, `disp_addr += BURST`; if result equals `FB_BASE+FB_WORDS`, it loads `FB_BASE` and `frame_wrap` pulses.
- FLUSH (one cycle): `fifo_clr`=1, `disp_addr`=`FB_BASE`, `flush_pend` cleared -> IDLE. Frame start and wrap in the same burst end: FLUSH result wins (address is `FB_BASE`), `frame_wrap` still pulses.
- `frame_start` mid-burst never aborts a burst; it is serviced after return to IDLE.

## Timing
- Reset: state IDLE, `disp_addr`=`FB_BASE`, `flush_pend`=0; all outputs 0, `rd_addr`=0.
- `rd_req` rises the cycle after the IDLE decision (registered); request-to-command latency = 1 cycle.
- `rd_req` drops the cycle after `rd_ack`.
- Return to IDLE the cycle after the last beat; minimum burst-to-burst gap = 1 IDLE cycle + 1 cycle to command.
- `fifo_clr` and `frame_wrap` are registered single-cycle pulses.
- Reset mid-burst abandons the burst; the SDRAM controller shares `rst`.

## Configuration
- `FB_READ_ARB_STATS_EN` defined: adds outputs `stat_urgent` (16 bits, counts urgent display grants) and `stat_cnn` (16 bits, counts CNN grants); both saturate at 0xFFFF and clear on `rst`.
- Not defined: ports absent, no counter logic.

## Test plan
- Reset, `fifo_wrusedw`=0, `rd_ack` after 2 cycles, 8 beats -> `rd_addr`=0, 8 `wr_fifo` pulses, next `rd_addr`=8.
- `fifo_wrusedw`=500 with `cnn_req` high, `cnn_addr`=0x100000 -> display granted first; at level 2000 the CNN wins, `cnn_ack` once, 8 `cnn_rvalid`.
- `fifo_wrusedw`=4090, no `cnn_req` -> `rd_req` stays 0.
- Run 9600 display bursts -> `frame_wrap` pulses once, next `rd_addr`=`FB_BASE`.
- `frame_start` during beat 3 of a display burst -> burst completes (8 beats), then one `fifo_clr`, next display `rd_addr`=`FB_BASE`.
- With `FB_READ_ARB_STATS_EN`: 3 CNN grants -> `stat_cnn`=3; after reset -> 0.
